// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port (I) and the load/store port (D). One access is in flight at a
// time; read data returns with a one-cycle ack after a fixed latency.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_req/if_addr              I-port read request (held until if_ack)
//   if_ack/if_rdata/if_stall    I-port completion pulse, data, stall
//   dm_req/dm_we/dm_addr/dm_wdata  D-port request (held until dm_ack)
//   dm_ack/dm_rdata/dm_stall    D-port completion pulse, data, stall
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata                   memory read data, valid MEM_LAT after mem_en
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned MEM_LAT       = 2,
    parameter int unsigned DATA_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             last_grant;
    logic             grant_c;
    logic             grant_owner_c;

    // Next-state and arbitration decision
    always_comb begin
        next_state    = state;
        grant_c       = 1'b0;
        grant_owner_c = OWN_I;
        case (state)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    grant_c    = 1'b1;
                    next_state = ST_ISSUE;
                    if (dm_req && !if_req) begin
                        grant_owner_c = OWN_D;
                    end else if (if_req && !dm_req) begin
                        grant_owner_c = OWN_I;
                    end else if (DATA_PRIORITY != 0) begin
                        grant_owner_c = OWN_D;
                    end else begin
                        // Round-robin tie break: the port not served last.
                        grant_owner_c = ~last_grant;
                    end
                end
            end
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (cnt == '0) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: command latch, latency counter, read capture, acks
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_c) begin
                        owner  <= grant_owner_c;
                        mem_en <= 1'b1;
                        if (grant_owner_c == OWN_D) begin
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            // Fetches are always reads; wdata keeps its value.
                            mem_we   <= 1'b0;
                            mem_addr <= if_addr;
                        end
                    end
                end
                ST_ISSUE: cnt <= CNT_INIT;
                ST_WAIT: begin
                    if (cnt == '0) begin
                        if (owner == OWN_D) begin
                            dm_ack <= 1'b1;
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: last_grant <= owner;
                default: ;
            endcase
        end
    end

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    // Main instance: MEM_LAT=2, DATA_PRIORITY=1
    logic        if_req, if_ack, if_stall;
    logic [7:0]  if_addr;
    logic [15:0] if_rdata;
    logic        dm_req, dm_we, dm_ack, dm_stall;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    // Round-robin instance: MEM_LAT=2, DATA_PRIORITY=0
    logic        p_if_req, p_if_ack, p_if_stall;
    logic [7:0]  p_if_addr;
    logic [15:0] p_if_rdata;
    logic        p_dm_req, p_dm_we, p_dm_ack, p_dm_stall;
    logic [7:0]  p_dm_addr;
    logic [15:0] p_dm_wdata, p_dm_rdata;
    logic        p_mem_en, p_mem_we;
    logic [7:0]  p_mem_addr;
    logic [15:0] p_mem_wdata, p_mem_rdata;

    // Minimum-latency instance: MEM_LAT=1, DATA_PRIORITY=1
    logic        l_if_req, l_if_ack, l_if_stall;
    logic [7:0]  l_if_addr;
    logic [15:0] l_if_rdata;
    logic        l_dm_req, l_dm_we, l_dm_ack, l_dm_stall;
    logic [7:0]  l_dm_addr;
    logic [15:0] l_dm_wdata, l_dm_rdata;
    logic        l_mem_en, l_mem_we;
    logic [7:0]  l_mem_addr;
    logic [15:0] l_mem_wdata, l_mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(2), .DATA_PRIORITY(1)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(2), .DATA_PRIORITY(0)) u_rr (
        .clk(clk), .reset(reset),
        .if_req(p_if_req), .if_addr(p_if_addr), .if_ack(p_if_ack), .if_rdata(p_if_rdata), .if_stall(p_if_stall),
        .dm_req(p_dm_req), .dm_we(p_dm_we), .dm_addr(p_dm_addr), .dm_wdata(p_dm_wdata),
        .dm_ack(p_dm_ack), .dm_rdata(p_dm_rdata), .dm_stall(p_dm_stall),
        .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
        .mem_rdata(p_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1), .DATA_PRIORITY(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(l_if_req), .if_addr(l_if_addr), .if_ack(l_if_ack), .if_rdata(l_if_rdata), .if_stall(l_if_stall),
        .dm_req(l_dm_req), .dm_we(l_dm_we), .dm_addr(l_dm_addr), .dm_wdata(l_dm_wdata),
        .dm_ack(l_dm_ack), .dm_rdata(l_dm_rdata), .dm_stall(l_dm_stall),
        .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
        .mem_rdata(l_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory for the main instance: data is driven only in the cycle
    // exactly two cycles after mem_en, 16'hDEAD otherwise.
    logic [15:0] mem [256];
    logic        v1, v2;
    logic [15:0] d1, d2;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        v1 <= mem_en && !mem_we;
        d1 <= mem[mem_addr];
        v2 <= v1;
        d2 <= d1;
    end
    assign mem_rdata = v2 ? d2 : 16'hDEAD;

    // Memory for the MEM_LAT=1 instance: valid only in the cycle after mem_en.
    logic l_v1;
    always @(posedge clk) l_v1 <= l_mem_en;
    assign l_mem_rdata = l_v1 ? 16'h0A05 : 16'hDEAD;

    assign p_mem_rdata = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The two acks of one instance must never be high together.
    always @(negedge clk) begin
        if (!reset && checks > 0) begin
            checks++;
            assert (!(if_ack === 1'b1 && dm_ack === 1'b1)) else begin
                errors++;
                $error("FAIL ack_overlap: observed if_ack=%0b dm_ack=%0b expected not both 1", if_ack, dm_ack);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h30] = 16'h3333;
        mem[8'h10] = 16'h1234;

        reset = 1'b1;
        if_req = 1'b1; if_addr = 8'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h30; dm_wdata = 16'h0000;
        p_if_req = 1'b0; p_if_addr = 8'h44;
        p_dm_req = 1'b0; p_dm_we = 1'b0; p_dm_addr = 8'h55; p_dm_wdata = 16'h0000;
        l_if_req = 1'b0; l_if_addr = 8'h00;
        l_dm_req = 1'b0; l_dm_we = 1'b0; l_dm_addr = 8'h05; l_dm_wdata = 16'h0000;

        // Reset held two cycles with both requests asserted
        tick(); tick();
        check("rst_mem_en",   32'(mem_en),    32'h0);
        check("rst_mem_we",   32'(mem_we),    32'h0);
        check("rst_mem_addr", 32'(mem_addr),  32'h0);
        check("rst_mem_wd",   32'(mem_wdata), 32'h0);
        check("rst_if_ack",   32'(if_ack),    32'h0);
        check("rst_dm_ack",   32'(dm_ack),    32'h0);
        check("rst_if_rdata", 32'(if_rdata),  32'h0);
        check("rst_dm_rdata", 32'(dm_rdata),  32'h0);
        reset = 1'b0;

        // Contention after reset: D first
        tick();
        check("cont_d_en",    32'(mem_en),   32'h1);
        check("cont_d_addr",  32'(mem_addr), 32'h30);
        check("cont_d_we",    32'(mem_we),   32'h0);
        check("cont_if_stall", 32'(if_stall), 32'h1);
        tick();
        check("cont_d_en_off", 32'(mem_en), 32'h0);
        tick();
        check("cont_d_noack", 32'(dm_ack),   32'h0);
        check("cont_d_stall", 32'(dm_stall), 32'h1);
        tick();
        check("cont_d_ack",   32'(dm_ack),   32'h1);
        check("cont_d_rdata", 32'(dm_rdata), 32'h3333);
        check("cont_d_unstall", 32'(dm_stall), 32'h0);
        dm_req = 1'b0;
        tick();
        check("cont_gap_en",  32'(mem_en), 32'h0);
        check("cont_gap_ack", 32'(dm_ack), 32'h0);
        // I served second
        tick();
        check("cont_i_en",    32'(mem_en),   32'h1);
        check("cont_i_addr",  32'(mem_addr), 32'h10);
        check("cont_i_we",    32'(mem_we),   32'h0);
        tick(); tick();
        check("cont_i_stall", 32'(if_stall), 32'h1);
        check("cont_i_noack", 32'(if_ack),   32'h0);
        tick();
        check("cont_i_ack",   32'(if_ack),   32'h1);
        check("cont_i_rdata", 32'(if_rdata), 32'h1234);
        check("cont_i_unstall", 32'(if_stall), 32'h0);
        if_req = 1'b0;
        tick();
        check("idle_en", 32'(mem_en), 32'h0);

        // D write, then a read of the same address
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h20; dm_wdata = 16'hBEEF;
        tick();
        check("wr_en",    32'(mem_en),    32'h1);
        check("wr_we",    32'(mem_we),    32'h1);
        check("wr_addr",  32'(mem_addr),  32'h20);
        check("wr_wdata", 32'(mem_wdata), 32'hBEEF);
        dm_addr = 8'h99; dm_wdata = 16'h1111;
        tick();
        check("wr_hold_wdata", 32'(mem_wdata), 32'hBEEF);
        check("wr_hold_addr",  32'(mem_addr),  32'h20);
        tick(); tick();
        check("wr_ack",   32'(dm_ack),   32'h1);
        check("wr_rdata_kept", 32'(dm_rdata), 32'h3333);
        dm_we = 1'b0; dm_addr = 8'h20;
        tick();
        check("rd_gap_en",  32'(mem_en), 32'h0);
        tick();
        check("rd_en",   32'(mem_en),   32'h1);
        check("rd_we",   32'(mem_we),   32'h0);
        check("rd_addr", 32'(mem_addr), 32'h20);
        tick(); tick(); tick();
        check("rd_ack",   32'(dm_ack),   32'h1);
        check("rd_rdata", 32'(dm_rdata), 32'hBEEF);
        dm_req = 1'b0;
        tick();

        // Reset one cycle after mem_en of an I read
        if_req = 1'b1; if_addr = 8'h10;
        tick();
        check("mrst_en", 32'(mem_en), 32'h1);
        tick();
        reset = 1'b1;
        tick();
        check("mrst_no_ack", 32'(if_ack),   32'h0);
        check("mrst_en_off", 32'(mem_en),   32'h0);
        check("mrst_rdata",  32'(if_rdata), 32'h0);
        check("mrst_addr",   32'(mem_addr), 32'h0);
        reset = 1'b0;
        tick();
        check("mrst_re_en",   32'(mem_en),   32'h1);
        check("mrst_re_addr", 32'(mem_addr), 32'h10);
        tick(); tick();
        check("mrst_re_noack", 32'(if_ack), 32'h0);
        tick();
        check("mrst_re_ack",   32'(if_ack),   32'h1);
        check("mrst_re_rdata", 32'(if_rdata), 32'h1234);
        if_req = 1'b0;
        tick();
        check("mrst_ack_pulse", 32'(if_ack), 32'h0);

        // DATA_PRIORITY=0: after a D grant, a tie goes to I
        p_dm_req = 1'b1;
        tick();
        check("rr_d1_en",   32'(p_mem_en),   32'h1);
        check("rr_d1_addr", 32'(p_mem_addr), 32'h55);
        tick(); tick(); tick();
        check("rr_d1_ack", 32'(p_dm_ack), 32'h1);
        p_if_req = 1'b1;
        tick();
        tick();
        check("rr_i_en",   32'(p_mem_en),   32'h1);
        check("rr_i_addr", 32'(p_mem_addr), 32'h44);
        tick(); tick(); tick();
        check("rr_i_ack",  32'(p_if_ack), 32'h1);
        check("rr_i_dack", 32'(p_dm_ack), 32'h0);
        p_if_req = 1'b0;
        tick();
        tick();
        check("rr_d2_addr", 32'(p_mem_addr), 32'h55);
        tick(); tick(); tick();
        check("rr_d2_ack", 32'(p_dm_ack), 32'h1);
        p_dm_req = 1'b0;
        tick();

        // MEM_LAT=1: single D read of 0x05
        l_dm_req = 1'b1;
        tick();
        check("lat1_en",   32'(l_mem_en),   32'h1);
        check("lat1_addr", 32'(l_mem_addr), 32'h05);
        tick();
        check("lat1_noack", 32'(l_dm_ack), 32'h0);
        tick();
        check("lat1_ack",   32'(l_dm_ack),   32'h1);
        check("lat1_rdata", 32'(l_dm_rdata), 32'h0A05);
        l_dm_req = 1'b0;
        tick();
        check("lat1_ack_pulse", 32'(l_dm_ack), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
